// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a one-entry MDU holding buffer.
// Pipeline has priority; a starvation counter forces a one-cycle stall to drain the MDU entry.
module core_wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pipe_valid_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,
  output logic            pipe_stall_o,
  input  logic            mdu_valid_i,
  output logic            mdu_ready_o,
  input  logic [4:0]      mdu_rd_i,
  input  logic [XLEN-1:0] mdu_data_i,
  output logic            pend_valid_o,
  output logic [4:0]      pend_rd_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RD_W  = 5;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HELD  = 2'd1,
    S_FORCE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RD_W-1:0]   buf_rd_d;
  logic [XLEN-1:0]   buf_data_q, buf_data_d;
  logic              we_d;
  logic [RD_W-1:0]   waddr_d;
  logic [XLEN-1:0]   wdata_d;
  logic              pipe_wr;

  // A pipeline write only competes for the port when it targets a real register.
  assign pipe_wr = pipe_valid_i && (pipe_rd_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_EMPTY;
      cnt_q        <= '0;
      pend_rd_o    <= '0;
      buf_data_q   <= '0;
      mdu_ready_o  <= 1'b1;
      pend_valid_o <= 1'b0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rd_o    <= buf_rd_d;
      buf_data_q   <= buf_data_d;
      mdu_ready_o  <= (state_d == S_EMPTY);
      pend_valid_o <= (state_d != S_EMPTY);
      rf_we_o      <= we_d;
      rf_waddr_o   <= waddr_d;
      rf_wdata_o   <= wdata_d;
    end
  end

  // Grant selection, buffer capture/release and starvation tracking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_rd_d     = pend_rd_o;
    buf_data_d   = buf_data_q;
    we_d         = 1'b0;
    waddr_d      = rf_waddr_o;
    wdata_d      = rf_wdata_o;
    pipe_stall_o = 1'b0;

    unique case (state_q)
      S_EMPTY: begin
        if (pipe_wr) begin
          we_d    = 1'b1;
          waddr_d = pipe_rd_i;
          wdata_d = pipe_data_i;
        end
        // Results for x0 are accepted but never buffered.
        if (mdu_valid_i && mdu_ready_o && (mdu_rd_i != '0)) begin
          state_d    = S_HELD;
          cnt_d      = '0;
          buf_rd_d   = mdu_rd_i;
          buf_data_d = mdu_data_i;
        end
      end
      S_HELD: begin
        if (!pipe_wr) begin
          we_d     = 1'b1;
          waddr_d  = pend_rd_o;
          wdata_d  = buf_data_q;
          state_d  = S_EMPTY;
          cnt_d    = '0;
          buf_rd_d = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = pipe_rd_i;
          wdata_d = pipe_data_i;
          if (pipe_rd_i == pend_rd_o) begin
            // Younger pipeline write to the same register supersedes the held result.
            state_d  = S_EMPTY;
            cnt_d    = '0;
            buf_rd_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == STARVE_MAX) begin
              state_d = S_FORCE;
            end
          end
        end
      end
      S_FORCE: begin
        pipe_stall_o = 1'b1;
        we_d         = 1'b1;
        waddr_d      = pend_rd_o;
        wdata_d      = buf_data_q;
        state_d      = S_EMPTY;
        cnt_d        = '0;
        buf_rd_d     = '0;
      end
      default: begin
        state_d  = S_EMPTY;
        cnt_d    = '0;
        buf_rd_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: expected register-file writes are queued by the
// stimulus and checked in order by an independent monitor; status outputs are checked inline.
module tb_core_wb_arbiter;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wr_t;

  logic            clk_i;
  logic            rst_ni;
  logic            pipe_valid_i;
  logic [4:0]      pipe_rd_i;
  logic [XLEN-1:0] pipe_data_i;
  logic            pipe_stall_o;
  logic            mdu_valid_i;
  logic            mdu_ready_o;
  logic [4:0]      mdu_rd_i;
  logic [XLEN-1:0] mdu_data_i;
  logic            pend_valid_o;
  logic [4:0]      pend_rd_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  core_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pipe_valid_i (pipe_valid_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_data_i  (pipe_data_i),
    .pipe_stall_o (pipe_stall_o),
    .mdu_valid_i  (mdu_valid_i),
    .mdu_ready_o  (mdu_ready_o),
    .mdu_rd_i     (mdu_rd_i),
    .mdu_data_i   (mdu_data_i),
    .pend_valid_o (pend_valid_o),
    .pend_rd_o    (pend_rd_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [XLEN-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every issued write must match the oldest expected write.
  always @(negedge clk_i) begin
    if (rst_ni && rf_we_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rf_write: unexpected write addr=%0d data=0x%0h", rf_waddr_o, rf_wdata_o);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (rf_waddr_o !== w.addr || rf_wdata_o !== w.data) begin
          bad++;
          $display("FAIL rf_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   rf_waddr_o, rf_wdata_o, w.addr, w.data);
        end
      end
    end
  end

  initial begin
    rst_ni       = 1'b0;
    pipe_valid_i = 1'b0;
    pipe_rd_i    = '0;
    pipe_data_i  = '0;
    mdu_valid_i  = 1'b0;
    mdu_rd_i     = '0;
    mdu_data_i   = '0;
    tick();
    tick();
    check("rst_we",        32'(rf_we_o), 0);
    check("rst_waddr",     32'(rf_waddr_o), 0);
    check("rst_wdata",     rf_wdata_o, 0);
    check("rst_ready",     32'(mdu_ready_o), 1);
    check("rst_pend",      32'(pend_valid_o), 0);
    check("rst_pend_rd",   32'(pend_rd_o), 0);
    check("rst_stall",     32'(pipe_stall_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Pipeline only: rd=3 writes, rd=0 does not.
    pipe_valid_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'h1234;
    expect_wr(5'd3, 32'h1234);
    tick();
    check("pipe_we", 32'(rf_we_o), 1);
    pipe_rd_i = 5'd0;
    tick();
    check("pipe_x0_we", 32'(rf_we_o), 0);
    pipe_valid_i = 1'b0;
    tick();

    // MDU result with idle pipeline.
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd7; mdu_data_i = 32'hDEADBEEF;
    check("mdu_ready_pre", 32'(mdu_ready_o), 1);
    tick();
    mdu_valid_i = 1'b0;
    check("mdu_pend_c1",  32'(pend_valid_o), 1);
    check("mdu_pendrd_c1", 32'(pend_rd_o), 7);
    check("mdu_ready_c1", 32'(mdu_ready_o), 0);
    check("mdu_we_c1",    32'(rf_we_o), 0);
    expect_wr(5'd7, 32'hDEADBEEF);
    tick();
    check("mdu_we_c2",    32'(rf_we_o), 1);
    check("mdu_ready_c2", 32'(mdu_ready_o), 1);
    check("mdu_pend_c2",  32'(pend_valid_o), 0);
    tick();

    // Starvation: four pipeline writes, forced stall, then x9, then the stalled write.
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd9; mdu_data_i = 32'h99;
    tick();
    mdu_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pipe_valid_i = 1'b1; pipe_rd_i = 5'(10 + i); pipe_data_i = 32'(32'h100 + i);
      #1;
      check("starve_nostall", 32'(pipe_stall_o), 0);
      expect_wr(5'(10 + i), 32'(32'h100 + i));
      tick();
    end
    pipe_rd_i = 5'd20; pipe_data_i = 32'h200;
    #1;
    check("starve_stall",   32'(pipe_stall_o), 1);
    check("starve_pend",    32'(pend_valid_o), 1);
    expect_wr(5'd9, 32'h99);
    tick();
    check("starve_mdu_addr", 32'(rf_waddr_o), 9);
    check("starve_stall_off", 32'(pipe_stall_o), 0);
    expect_wr(5'd20, 32'h200);
    tick();
    pipe_valid_i = 1'b0;
    check("starve_pipe_addr", 32'(rf_waddr_o), 20);
    tick();

    // Port opens via a pipeline write to x0.
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd4; mdu_data_i = 32'h44;
    tick();
    mdu_valid_i = 1'b0;
    pipe_valid_i = 1'b1; pipe_rd_i = 5'd0; pipe_data_i = 32'hFFFF;
    #1;
    check("open_nostall", 32'(pipe_stall_o), 0);
    expect_wr(5'd4, 32'h44);
    tick();
    pipe_valid_i = 1'b0;
    check("open_waddr", 32'(rf_waddr_o), 4);
    tick();

    // WAW: younger pipeline write to the held register wins.
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd6; mdu_data_i = 32'h66;
    tick();
    mdu_valid_i = 1'b0;
    pipe_valid_i = 1'b1; pipe_rd_i = 5'd6; pipe_data_i = 32'h55;
    expect_wr(5'd6, 32'h55);
    tick();
    pipe_valid_i = 1'b0;
    check("waw_wdata", rf_wdata_o, 32'h55);
    check("waw_pend",  32'(pend_valid_o), 0);
    check("waw_ready", 32'(mdu_ready_o), 1);
    tick();
    check("waw_no_mdu", 32'(rf_we_o), 0);

    // MDU result for x0 is accepted and dropped.
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd0; mdu_data_i = 32'h77;
    tick();
    mdu_valid_i = 1'b0;
    check("x0_pend",  32'(pend_valid_o), 0);
    check("x0_ready", 32'(mdu_ready_o), 1);
    tick();
    check("x0_we", 32'(rf_we_o), 0);

    // Reset while holding rd=5 discards the entry.
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd5; mdu_data_i = 32'h5555;
    tick();
    mdu_valid_i = 1'b0;
    check("rst_mid_held", 32'(pend_valid_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_pend",   32'(pend_valid_o), 0);
    check("rst_mid_pendrd", 32'(pend_rd_o), 0);
    check("rst_mid_ready",  32'(mdu_ready_o), 1);
    check("rst_mid_we",     32'(rf_we_o), 0);
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) tick();
    check("rst_mid_after_pend", 32'(pend_valid_o), 0);
    check("sb_drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter.md
Name: core_wb_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback result and results from the multi-cycle M-extension unit (MDU). MDU results are captured in a one-entry holding buffer. Pipeline writes have priority. A starvation counter forces a one-cycle pipeline stall so that a held MDU result is eventually written. The block sits between the writeback stage output and the register file, and exports the pending destination register to decode for interlocking.

Parameters:
XLEN, 32, data width
STARVE_LIMIT, 4, cycles a held MDU result may wait before the pipeline is forced to stall (legal range 1..15)

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
pipe_valid_i  input  1  pipeline writeback valid this cycle
pipe_rd_i  input  5  pipeline destination register
pipe_data_i  input  XLEN  pipeline writeback data
pipe_stall_o  output  1  combinational; pipeline must hold its writeback this cycle
mdu_valid_i  input  1  MDU result valid
mdu_ready_o  output  1  registered; holding buffer empty
mdu_rd_i  input  5  MDU destination register
mdu_data_i  input  XLEN  MDU result
pend_valid_o  output  1  registered; MDU result held and not yet written
pend_rd_o  output  5  registered; destination of the held MDU result
rf_we_o  output  1  registered register-file write enable
rf_waddr_o  output  5  registered write address
rf_wdata_o  output  XLEN  registered write data

Behaviour:
- Reset (async, rst_ni=0): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, buffer empty, mdu_ready_o=1, pend_valid_o=0, pend_rd_o=0, starve counter=0, state=EMPTY, pipe_stall_o=0. Reset mid-operation discards any held MDU result.
- States:
  - EMPTY: buffer empty.
  - HELD: buffer full, waiting for the port.
  - FORCE: buffer full and the counter has reached STARVE_LIMIT.
- MDU handshake: capture happens on the rising edge where mdu_valid_i & mdu_ready_o. Transition EMPTY->HELD. mdu_ready_o=0 while HELD or FORCE. An MDU result with mdu_rd_i=0 is accepted and dropped; the state stays EMPTY.
- Port free this cycle: pipe_valid_i=0, or pipe_valid_i=1 with pipe_rd_i=0.
- Grant rules, evaluated each cycle:
  - FORCE: pipe_stall_o=1. The MDU entry is granted. Any pipeline write is not taken this cycle. Next state is EMPTY.
  - HELD and port free: MDU granted. Next state is EMPTY. No stall.
  - HELD and pipeline writing a nonzero rd: pipeline granted. Counter increments. When the counter reaches STARVE_LIMIT, next state is FORCE.
  - EMPTY: pipeline granted when pipe_valid_i=1 and pipe_rd_i!=0.
- WAW case: in HELD, if the pipeline writes the same nonzero rd as the held entry, the held entry is discarded (the younger write wins), and next state is EMPTY. In FORCE, the stall takes precedence: the MDU write goes first, then the pipeline write on the following cycle.
- Grant output timing: the granted write appears on rf_we_o/rf_waddr_o/rf_wdata_o at the next rising edge. rf_we_o=0 on cycles with no grant. Writes to x0 are never issued.
- Latency: pipeline write 1 cycle. MDU write 2 cycles minimum after the handshake (capture, then grant). Maximum is STARVE_LIMIT+2 cycles.
- Counter: 4 bits. Cleared on capture, on grant, on discard and on reset.
- pend_valid_o and pend_rd_o mirror the buffer state; pend_valid_o=1 in HELD and FORCE. Decode must interlock reads of pend_rd_o. pend_valid_o clears on the same edge where the grant is registered.
- A new MDU capture cannot coincide with a grant, because ready is registered. Throughput is at most one MDU result per 2 cycles.

Test Plan:
- Reset asserted mid-HELD (held entry rd=5) -> outputs take their reset values immediately, no write to x5 appears, and mdu_ready_o=1.
- Pipeline only: pipe_valid_i=1, rd=3, data=0x1234 -> next cycle rf_we_o=1, waddr=3, wdata=0x1234. Same stimulus with rd=0 -> rf_we_o=0.
- MDU with an idle pipeline: handshake at cycle 0 with rd=7, data=0xDEADBEEF -> pend_valid_o=1 and pend_rd_o=7 at cycle 1; rf_we_o=1, waddr=7, wdata=0xDEADBEEF at cycle 2; mdu_ready_o=1 again at cycle 2.
- Starvation: MDU rd=9 held while the pipeline writes nonzero rd every cycle -> exactly 4 pipeline writes, then pipe_stall_o=1 for one cycle, then x9 written. The stalled pipeline write is written on the following cycle.
- Port opening: MDU rd=4 held, then the pipeline writes rd=0 -> MDU granted that cycle, no stall, and rf_waddr_o=4 on the next cycle.
- WAW: MDU rd=6 held, then the pipeline writes rd=6, data=0x55 -> only the 0x55 write occurs, pend_valid_o clears, and mdu_ready_o=1 on the next cycle.
